// File: rtl/coe_out_pp_buf.sv
// Ping-pong coefficient output buffer: one bank fills by random-address
// writes while the other streams out in order on a valid/ready port.
module coe_out_pp_buf #(
  parameter int DWIDTH = 160,
  parameter int AWIDTH = 10,
  parameter int WORDS  = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wen,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0] wdat,
  input  logic              wr_done,
  input  logic [AWIDTH:0]   wr_len,
  output logic              wr_ready,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DWIDTH-1:0] rd_dat,
  output logic              rd_last,
  output logic              ovf_err
);

  localparam int LW = AWIDTH + 1;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } rd_st_t;

  logic [DWIDTH-1:0] mem [2][WORDS];

  logic [1:0]        filled;
  logic [LW-1:0]     len [2];
  logic              wbank;
  logic              rbank;
  rd_st_t            st;
  logic [AWIDTH-1:0] raddr;

  logic              inf_v;
  logic              inf_last;
  logic [DWIDTH-1:0] inf_dat;

  logic [DWIDTH-1:0] fdat [2];
  logic [1:0]        flst;
  logic              wp;
  logic              rp;
  logic [1:0]        cnt;

  logic              wr_acc;
  logic              close;
  logic [LW-1:0]     len_clamp;
  logic              pop;
  logic              rel;
  logic [2:0]        occ;
  logic              issue;
  logic              is_last;

  assign wr_ready  = !filled[wbank];
  assign wr_acc    = wen & wr_ready;
  assign close     = wr_done & wr_ready & (wr_len != '0);
  assign len_clamp = (wr_len > LW'(WORDS)) ? LW'(WORDS) : wr_len;

  assign rd_valid  = (cnt != 2'd0);
  assign rd_dat    = fdat[rp];
  assign rd_last   = flst[rp] & rd_valid;
  assign pop       = rd_valid & rd_ready;
  assign rel       = (st == DRAIN) & pop & rd_last;

  // Occupancy after this cycle's pop; keeps the 2-entry FIFO from overflowing
  assign occ     = {1'b0, cnt} + {2'b0, inf_v} - {2'b0, pop};
  assign issue   = (st == STREAM) & (occ < 3'd2);
  assign is_last = ({1'b0, raddr} == len[rbank] - LW'(1));

  always_ff @(posedge clk) begin
    if (wr_acc)
      mem[wbank][waddr] <= wdat;
    if (issue)
      inf_dat <= mem[rbank][raddr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filled   <= '0;
      len[0]   <= '0;
      len[1]   <= '0;
      wbank    <= 1'b0;
      rbank    <= 1'b0;
      ovf_err  <= 1'b0;
      st       <= IDLE;
      raddr    <= '0;
      inf_v    <= 1'b0;
      inf_last <= 1'b0;
    end else begin
      if ((wen | wr_done) & !wr_ready)
        ovf_err <= 1'b1;
      if (close) begin
        filled[wbank] <= 1'b1;
        len[wbank]    <= len_clamp;
        wbank         <= ~wbank;
      end
      // close and release never target the same bank
      if (rel) begin
        filled[rbank] <= 1'b0;
        rbank         <= ~rbank;
      end
      inf_v <= issue;
      if (issue)
        inf_last <= is_last;
      case (st)
        IDLE: begin
          if (filled[rbank]) begin
            st    <= STREAM;
            raddr <= '0;
          end
        end
        STREAM: begin
          if (issue) begin
            raddr <= raddr + AWIDTH'(1);
            if (is_last)
              st <= DRAIN;
          end
        end
        DRAIN: begin
          if (rel)
            st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fdat[0] <= '0;
      fdat[1] <= '0;
      flst    <= '0;
      wp      <= 1'b0;
      rp      <= 1'b0;
      cnt     <= 2'd0;
    end else begin
      if (inf_v) begin
        fdat[wp] <= inf_dat;
        flst[wp] <= inf_last;
        wp       <= ~wp;
      end
      if (pop)
        rp <= ~rp;
      cnt <= cnt + {1'b0, inf_v} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_coe_out_pp_buf.sv
// Scoreboard bench for coe_out_pp_buf: bank-level model queues expected
// words on each accepted close; a negedge monitor checks the stream.
module tb_coe_out_pp_buf;

  localparam int DW    = 160;
  localparam int AW    = 10;
  localparam int WORDS = 1024;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wen = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic [DW-1:0] wdat = '0;
  logic          wr_done = 1'b0;
  logic [AW:0]   wr_len = '0;
  logic          wr_ready;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [DW-1:0] rd_dat;
  logic          rd_last;
  logic          ovf_err;

  always #5 clk = ~clk;

  coe_out_pp_buf #(.DWIDTH(DW), .AWIDTH(AW), .WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .wen(wen), .waddr(waddr), .wdat(wdat),
    .wr_done(wr_done), .wr_len(wr_len), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_dat(rd_dat), .rd_last(rd_last), .ovf_err(ovf_err)
  );

  typedef struct {
    logic [DW-1:0] d;
    bit            l;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] mm [2][WORDS];
  bit            mfilled [2];
  bit            mbank = 1'b0;
  bit            mrb = 1'b0;
  bit            exp_ovf = 1'b0;

  int errors = 0;
  int checks = 0;
  int rr_mode = 0;
  int n_acc = 0;
  int cyc = 0;
  int last_cyc = 0;
  bit chk_gap = 1'b0;
  bit prev_last = 1'b0;
  bit pst = 1'b0;
  logic [DW-1:0] pd;
  logic          pl;

  function automatic void chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  function automatic void chkb(string nm, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endfunction

  function automatic logic [DW-1:0] rnd();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (rr_mode == 1)
      rd_ready = 1'b1;
    else if (rr_mode == 2)
      rd_ready = 1'($urandom_range(0, 1));
    else
      rd_ready = 1'b0;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      pst = 1'b0;
    end else begin
      if (pst) begin
        chkb("stall_valid", rd_valid, 1'b1);
        chk("stall_dat", rd_dat, pd);
        chkb("stall_last", rd_last, pl);
      end
      if (rd_valid && rd_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %0h want none", rd_dat);
        end else begin
          e = q.pop_front();
          chk("rd_dat", rd_dat, e.d);
          chkb("rd_last", rd_last, e.l);
          if (chk_gap && prev_last)
            chkb("bank_gap", (cyc - last_cyc) <= 4, 1'b1);
          prev_last = e.l;
          last_cyc = cyc;
          if (e.l) begin
            mfilled[mrb] = 1'b0;
            mrb = ~mrb;
          end
          n_acc++;
        end
      end
      pst = rd_valid && !rd_ready;
      pd = rd_dat;
      pl = rd_last;
    end
  end

  task automatic do_cycle(input bit w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input bit dn,
                          input logic [AW:0] ln);
    int L;
    chkb("wr_ready", wr_ready, !mfilled[mbank]);
    wen = w;
    waddr = a;
    wdat = d;
    wr_done = dn;
    wr_len = ln;
    if (w || dn) begin
      if (mfilled[mbank]) begin
        exp_ovf = 1'b1;
      end else begin
        if (w)
          mm[mbank][a] = d;
        if (dn && ln != 0) begin
          L = (int'(ln) > WORDS) ? WORDS : int'(ln);
          for (int i = 0; i < L; i++)
            q.push_back('{mm[mbank][i], i == L - 1});
          mfilled[mbank] = 1'b1;
          mbank = ~mbank;
        end
      end
    end
    @(posedge clk);
    #1;
    wen = 1'b0;
    wr_done = 1'b0;
    chkb("ovf_err", ovf_err, exp_ovf);
  endtask

  task automatic idle(input int n);
    repeat (n) do_cycle(1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic fill_close(input int n, input logic [AW:0] ln, input bit merge);
    int ord[$];
    int j;
    int t;
    for (int i = 0; i < n; i++)
      ord.push_back(i);
    for (int i = n - 1; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      t = ord[i];
      ord[i] = ord[j];
      ord[j] = t;
    end
    for (int i = 0; i < n; i++) begin
      if (merge && i == n - 1)
        do_cycle(1'b1, AW'(ord[i]), rnd(), 1'b1, ln);
      else
        do_cycle(1'b1, AW'(ord[i]), rnd(), 1'b0, '0);
    end
    if (!merge)
      do_cycle(1'b0, '0, '0, 1'b1, ln);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20000; i++) begin
      if (q.size() == 0 && !mfilled[0] && !mfilled[1])
        break;
      idle(1);
    end
    chkb("drain_timeout", q.size() == 0 && !mfilled[0] && !mfilled[1], 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mfilled[0] = 1'b0;
    mfilled[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chkb("rst_wr_ready", wr_ready, 1'b1);
    chkb("rst_rd_valid", rd_valid, 1'b0);
    chkb("rst_rd_last", rd_last, 1'b0);
    chk("rst_rd_dat", rd_dat, '0);
    chkb("rst_ovf", ovf_err, 1'b0);
    rst_n = 1'b1;

    // basic 4-word bank, latency and back-to-back delivery
    rr_mode = 1;
    for (int i = 0; i < 4; i++)
      do_cycle(1'b1, AW'(i), DW'(32'hA0 + i), 1'b0, '0);
    do_cycle(1'b0, '0, '0, 1'b1, 11'd4);
    chkb("lat_e0", rd_valid, 1'b0);
    idle(1);
    chkb("lat_e1", rd_valid, 1'b0);
    idle(1);
    chkb("lat_e2", rd_valid, 1'b0);
    idle(1);
    chkb("lat_e3", rd_valid, 1'b1);
    for (int k = 0; k < 3; k++) begin
      idle(1);
      chkb("no_bubble", rd_valid, 1'b1);
    end
    idle(1);
    chkb("t1_done_valid", rd_valid, 1'b0);
    chkb("t1_wr_ready", wr_ready, 1'b1);

    // both banks full, then overflow attempts
    rr_mode = 0;
    fill_close(8, 11'd8, 1'b0);
    fill_close(8, 11'd8, 1'b0);
    chkb("full_wr_ready", wr_ready, 1'b0);
    do_cycle(1'b1, '0, rnd(), 1'b0, '0);
    do_cycle(1'b0, '0, '0, 1'b1, 11'd8);
    idle(5);
    rr_mode = 2;
    wait_drain();

    // reset mid-stream
    rr_mode = 1;
    n_acc = 0;
    fill_close(16, 11'd16, 1'b0);
    for (int i = 0; i < 100 && n_acc < 5; i++)
      idle(1);
    chkb("reset_reach5", n_acc >= 5, 1'b1);
    rst_n = 1'b0;
    #1;
    chkb("mid_rst_valid", rd_valid, 1'b0);
    chkb("mid_rst_wr_ready", wr_ready, 1'b1);
    chkb("mid_rst_ovf", ovf_err, 1'b0);
    q.delete();
    mfilled[0] = 1'b0;
    mfilled[1] = 1'b0;
    mbank = 1'b0;
    mrb = 1'b0;
    exp_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    fill_close(6, 11'd6, 1'b1);
    wait_drain();

    // zero-length close
    do_cycle(1'b0, '0, '0, 1'b1, '0);
    for (int k = 0; k < 6; k++) begin
      idle(1);
      chkb("len0_no_valid", rd_valid, 1'b0);
    end
    fill_close(5, 11'd5, 1'b0);
    wait_drain();

    // full bank with random backpressure, then clamped length
    rr_mode = 2;
    fill_close(WORDS, 11'(WORDS), 1'b0);
    fill_close(WORDS, 11'h7FF, 1'b1);
    wait_drain();

    // back-to-back short banks
    rr_mode = 0;
    fill_close(3, 11'd3, 1'b1);
    fill_close(5, 11'd5, 1'b0);
    idle(4);
    prev_last = 1'b0;
    chk_gap = 1'b1;
    rr_mode = 1;
    wait_drain();
    chk_gap = 1'b0;
    idle(2);

    chkb("queue_empty", q.size() == 0, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
